// File: rtl/gate_bist.sv
// Built-in self-test sequencer for single-output library gates: sweeps every
// input vector on A, waits SETTLE cycles, checks Y against the truth table and
// reports pass/fail, mismatch count and the first failing vector.
module gate_bist #(
    parameter int unsigned N_INPUTS = 2,
    parameter int unsigned SETTLE   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [2:0]          op,
    output logic [N_INPUTS-1:0] A,
    input  logic                Y,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N_INPUTS:0]   err_count,
    output logic [N_INPUTS-1:0] first_fail_vec
);

    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned ERR_W = N_INPUTS + 1;

    localparam logic [2:0] OP_NOT  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_XNOR = 3'b110;
    localparam logic [2:0] OP_BUF  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t           state;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] settle_cnt;

    logic             expected_c;
    logic             mismatch_c;
    logic [ERR_W-1:0] err_next_c;

    // Truth-table value of the latched gate type for the vector currently on A
    always_comb begin
        expected_c = 1'b0;
        case (op_q)
            OP_NOT:  expected_c = ~A[0];
            OP_AND:  expected_c = &A;
            OP_OR:   expected_c = |A;
            OP_NAND: expected_c = ~(&A);
            OP_NOR:  expected_c = ~(|A);
            OP_XOR:  expected_c = ^A;
            OP_XNOR: expected_c = ~(^A);
            OP_BUF:  expected_c = A[0];
            default: expected_c = 1'b0;
        endcase
    end

    // Mismatch and the error count it would produce; only consumed in SAMPLE
    always_comb begin
        mismatch_c = (Y != expected_c);
        err_next_c = err_count + ERR_W'(mismatch_c);
    end

    // Sequencer: latch op, sweep vectors, settle, sample, summarise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            op_q           <= 3'b000;
            settle_cnt     <= '0;
            A              <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail_vec <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q           <= op;
                        err_count      <= '0;
                        first_fail_vec <= '0;
                        pass           <= 1'b0;
                        A              <= '0;
                        settle_cnt     <= '0;
                        busy           <= 1'b1;
                        state          <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (settle_cnt == CNT_W'(SETTLE - 1)) begin
                        state <= S_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end
                S_SAMPLE: begin
                    if (mismatch_c) begin
                        err_count <= err_next_c;
                        // err_count is still zero only before the first mismatch
                        if (err_count == '0) begin
                            first_fail_vec <= A;
                        end
                    end
                    if (&A) begin
                        // pass must already reflect the last vector while done is high
                        pass  <= (err_next_c == '0);
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        A          <= A + N_INPUTS'(1);
                        settle_cnt <= '0;
                        state      <= S_DRIVE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_bist.sv
// Self-checking bench for gate_bist: two instances (1-input/SETTLE 1 and
// 2-input/SETTLE 2) driven by a behavioural gate with optional faults.
module tb_gate_bist;

    logic       clk;
    logic       rst_n;
    logic       start1, start2;
    logic [2:0] op1, op2;
    logic [0:0] a1;
    logic [1:0] a2;
    logic       y1, y2;
    logic       busy1, busy2, done1, done2, pass1, pass2;
    logic [1:0] err1;
    logic [2:0] err2;
    logic [0:0] ffv1;
    logic [1:0] ffv2;

    // Behaviour of the gate under test: real gate of type gop, or stuck, then flipped per vector
    logic [2:0] gop;
    int         ymode;   // 0 = real gate, 1 = stuck 0, 2 = stuck 1
    logic [7:0] flip;

    int checks = 0;
    int errors = 0;
    int sel    = 1;

    gate_bist #(.N_INPUTS(1), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op(op1), .A(a1), .Y(y1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_fail_vec(ffv1)
    );

    gate_bist #(.N_INPUTS(2), .SETTLE(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .op(op2), .A(a2), .Y(y2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .first_fail_vec(ffv2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truth table from the count of ones among the n input bits
    function automatic logic gate_ref(input logic [2:0] o, input int v, input int n);
        int ones;
        ones = 0;
        for (int i = 0; i < n; i++) ones += (v >> i) & 1;
        case (o)
            3'd0: return (v & 1) == 0;
            3'd1: return ones == n;
            3'd2: return ones != 0;
            3'd3: return ones != n;
            3'd4: return ones == 0;
            3'd5: return (ones % 2) == 1;
            3'd6: return (ones % 2) == 0;
            default: return (v & 1) == 1;
        endcase
    endfunction

    function automatic logic y_model(input logic [2:0] g, input int mode, input logic [7:0] f,
                                     input int v, input int n);
        logic base;
        if (mode == 1)      base = 1'b0;
        else if (mode == 2) base = 1'b1;
        else                base = gate_ref(g, v, n);
        return base ^ f[v];
    endfunction

    assign y1 = y_model(gop, ymode, flip, int'(a1), 1);
    assign y2 = y_model(gop, ymode, flip, int'(a2), 2);

    // Outputs of the selected instance, widened for comparison
    logic [31:0] m_a, m_err, m_ffv;
    logic        m_busy, m_done, m_pass;
    assign m_a    = (sel == 2) ? 32'(a2)   : 32'(a1);
    assign m_err  = (sel == 2) ? 32'(err2) : 32'(err1);
    assign m_ffv  = (sel == 2) ? 32'(ffv2) : 32'(ffv1);
    assign m_busy = (sel == 2) ? busy2 : busy1;
    assign m_done = (sel == 2) ? done2 : done1;
    assign m_pass = (sel == 2) ? pass2 : pass1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_start(input int which, input logic v);
        if (which == 2) start2 = v;
        else            start1 = v;
    endtask

    task automatic set_op(input int which, input logic [2:0] o);
        if (which == 2) op2 = o;
        else            op1 = o;
    endtask

    // One full run; expected results come from sweeping the model over every vector
    task automatic run(input int which, input logic [2:0] op_in, input logic [2:0] g,
                       input int mode, input logic [7:0] f, input bit glitch);
        int n, s, nv, per, c, exp_err, exp_ff, extra;
        bit seen, exp_pass;
        n   = (which == 2) ? 2 : 1;
        s   = (which == 2) ? 2 : 1;
        nv  = 1 << n;
        per = s + 1;
        exp_err = 0;
        exp_ff  = 0;
        for (int v = 0; v < nv; v++) begin
            if (y_model(g, mode, f, v, n) != gate_ref(op_in, v, n)) begin
                if (exp_err == 0) exp_ff = v;
                exp_err++;
            end
        end
        exp_pass = (exp_err == 0);

        @(negedge clk);
        sel = which; gop = g; ymode = mode; flip = f;
        set_op(which, op_in);
        set_start(which, 1'b1);
        @(negedge clk);
        set_start(which, 1'b0);
        c = 0;
        check("start_busy", 32'(m_busy), 32'd1);
        check("start_a", m_a, 32'd0);
        check("start_err_clr", m_err, 32'd0);
        check("start_pass_clr", 32'(m_pass), 32'd0);

        seen = 0;
        while (!seen && c < 200) begin
            @(negedge clk);
            c++;
            if (m_done) seen = 1;
            else check("a_seq", m_a, 32'((c / per < nv) ? c / per : nv - 1));
            if (glitch && c == 3) begin
                set_start(which, 1'b1);
                set_op(which, 3'($urandom_range(0, 7)));
            end
            if (glitch && c == 4) set_start(which, 1'b0);
        end
        check("done_seen", 32'(seen), 32'd1);
        check("done_cycle", 32'(c), 32'(nv * per));
        check("done_busy", 32'(m_busy), 32'd1);
        check("done_a", m_a, 32'(nv - 1));
        check("err_count", m_err, 32'(exp_err));
        check("first_fail", m_ffv, 32'(exp_ff));
        check("pass", 32'(m_pass), 32'(exp_pass));

        @(negedge clk);
        check("post_busy", 32'(m_busy), 32'd0);
        check("post_done", 32'(m_done), 32'd0);
        if (glitch) begin
            extra = 0;
            for (int i = 0; i < nv * per + 4; i++) begin
                @(negedge clk);
                if (m_done) extra++;
            end
            check("no_restart", 32'(extra), 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        check("pass_held", 32'(m_pass), 32'(exp_pass));
        check("err_held", m_err, 32'(exp_err));
    endtask

    initial begin
        int c, dones;
        logic [2:0] r_op, r_g;
        rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; op1 = 3'd0; op2 = 3'd0;
        gop = 3'd0; ymode = 0; flip = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state of both instances
        for (int w = 1; w <= 2; w++) begin
            sel = w;
            #1;
            check("rst_a", m_a, 32'd0);
            check("rst_busy", 32'(m_busy), 32'd0);
            check("rst_done", 32'(m_done), 32'd0);
            check("rst_pass", 32'(m_pass), 32'd0);
            check("rst_err", m_err, 32'd0);
            check("rst_ffv", m_ffv, 32'd0);
        end
        rst_n = 1'b1;

        // Directed cases
        run(1, 3'd0, 3'd0, 0, 8'h00, 0);   // NOT with a real inverter
        run(1, 3'd0, 3'd0, 2, 8'h00, 0);   // NOT, Y stuck at 1
        run(2, 3'd1, 3'd2, 0, 8'h00, 0);   // AND checked against an OR gate
        run(2, 3'd5, 3'd5, 1, 8'h00, 0);   // XOR, Y stuck at 0
        run(2, 3'd5, 3'd5, 0, 8'h00, 0);   // XOR re-run with a good gate
        run(2, 3'd3, 3'd3, 0, 8'h04, 1);   // NAND, one fault, start/op poked mid-run

        // Reset during DRIVE of vector 2 on the 2-input instance
        @(negedge clk);
        sel = 2; gop = 3'd1; ymode = 0; flip = 8'h00;
        op2 = 3'd1; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        c = 0;
        while (c < 6) begin
            @(negedge clk);
            c++;
        end
        check("pre_rst_a", m_a, 32'd2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_a", m_a, 32'd0);
        check("mid_rst_busy", 32'(m_busy), 32'd0);
        check("mid_rst_done", 32'(m_done), 32'd0);
        check("mid_rst_pass", 32'(m_pass), 32'd0);
        check("mid_rst_err", m_err, 32'd0);
        check("mid_rst_ffv", m_ffv, 32'd0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_done) dones++;
        end
        check("mid_rst_no_done", 32'(dones), 32'd0);
        run(2, 3'd4, 3'd4, 0, 8'h00, 0);

        // start held high: one IDLE cycle between back-to-back runs
        @(negedge clk);
        sel = 1; gop = 3'd0; ymode = 0; flip = 8'h00;
        op1 = 3'd0; start1 = 1'b1;
        c = 0;
        while (!m_done && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("b2b_done1", 32'(m_done), 32'd1);
        @(negedge clk);
        check("b2b_idle_busy", 32'(m_busy), 32'd0);
        @(negedge clk);
        check("b2b_restart_busy", 32'(m_busy), 32'd1);
        check("b2b_restart_a", m_a, 32'd0);
        start1 = 1'b0;
        c = 0;
        while (!m_done && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("b2b_done2", 32'(m_done), 32'd1);
        check("b2b_pass", 32'(m_pass), 32'd1);
        @(negedge clk);

        // Randomised runs: random gate type, sometimes the wrong gate, random faults
        for (int k = 0; k < 12; k++) begin
            r_op = 3'($urandom_range(0, 7));
            r_g  = ($urandom_range(0, 1) == 0) ? r_op : 3'($urandom_range(0, 7));
            run(int'($urandom_range(1, 2)), r_op, r_g, int'($urandom_range(0, 2)),
                8'($urandom_range(0, 255)) & (($urandom_range(0, 2) == 0) ? 8'h00 : 8'hff), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
